// File: rtl/fifo_read_pkg.sv
// Shared types and defaults for the asynchronous-FIFO read-side packer.
package fifo_read_pkg;

    typedef enum logic {
        FILL = 1'b0,
        LOAD = 1'b1
    } fill_st_t;

    localparam int DW_DEF   = 2;
    localparam int PACK_DEF = 4;

    // Width needed to hold a fill count in the range 0..pack.
    function automatic int cnt_width(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/fifo_read_out_reg.sv
// Valid/ready holding register for the packed output word.
module fifo_read_out_reg
    import fifo_read_pkg::*;
#(
    parameter int OW = DW_DEF * PACK_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [OW-1:0] data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [OW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [OW-1:0] data_q, data_d;

    // A load wins over a transfer, so a simultaneous transfer+load keeps valid high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fifo_read_packer.sv
// Pops DW-bit words from the async FIFO read port and packs PACK of them,
// first word in the LSBs, into one OW-bit word on a valid/ready stream.
// Optional build macro FIFO_READ_PACKER_STATS_EN adds pop_cnt/stall_cnt outputs.
module fifo_read_packer
    import fifo_read_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int PACK = PACK_DEF,
    parameter int OW   = DW * PACK
) (
    input  logic          rclk,
    input  logic          rrst,
    input  logic          rempty,
    input  logic [DW-1:0] rdata,
    output logic          rd,
    output logic          m_valid,
    output logic [OW-1:0] m_data,
    input  logic          m_ready
`ifdef FIFO_READ_PACKER_STATS_EN
    ,
    output logic [15:0]   pop_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int             CW        = cnt_width(PACK);
    localparam logic [CW-1:0]  FULL_CNT  = CW'(PACK);
    localparam logic [CW:0]    PACK_WIDE = (CW + 1)'(PACK);

    fill_st_t      state_q, state_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;
    logic          pend_q, pend_d;
    logic          load;
    logic [CW:0]   in_use;

    // Words already stored plus the one in flight must never exceed PACK.
    assign in_use = {1'b0, acc_cnt_q} + {{CW{1'b0}}, pend_q};
    assign rd     = !rrst && !rempty && (in_use < PACK_WIDE);

    // Next-state: capture the in-flight word, then hand the full accumulator to the output slot.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        pend_d    = rd;
        load      = 1'b0;
        if (pend_q) begin
            for (int unsigned i = 0; i < PACK; i++) begin
                if (acc_cnt_q == CW'(i)) begin
                    acc_d[i*DW +: DW] = rdata;
                end
            end
            acc_cnt_d = acc_cnt_q + CW'(1);
        end
        case (state_q)
            FILL: begin
                if (acc_cnt_d == FULL_CNT) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!m_valid || m_ready) begin
                    load      = 1'b1;
                    acc_cnt_d = '0;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State registers; reset also discards any pop still in flight.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q   <= FILL;
            acc_q     <= '0;
            acc_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
            pend_q    <= pend_d;
        end
    end

    fifo_read_out_reg #(.OW(OW)) u_out_reg (
        .clk_i   (rclk),
        .rst_i   (rrst),
        .load_i  (load),
        .data_i  (acc_q),
        .ready_i (m_ready),
        .valid_o (m_valid),
        .data_o  (m_data)
    );

`ifdef FIFO_READ_PACKER_STATS_EN
    logic [15:0] pop_cnt_q, pop_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Pop counter wraps; stall counter saturates at all-ones.
    always_comb begin
        pop_cnt_d   = pop_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (rd) begin
            pop_cnt_d = pop_cnt_q + 16'd1;
        end
        if (m_valid && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            pop_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pop_cnt_q   <= pop_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pop_cnt   = pop_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
